evt_readout_ctrl: RTL



---
 rtl/evt_readout_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/evt_readout_ctrl.sv
// rtl/evt_readout_ctrl.sv - arbiter readout FSM, grant encoder and FWFT event FIFO
// Define EVT_TIMESTAMP_EN to add the timestamp counter and its field in evt_data_o MSBs.
module evt_readout_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int X_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int Y_W       = (COLS > 1) ? $clog2(COLS) : 1,
`ifdef EVT_TIMESTAMP_EN
  localparam int EVT_W     = TS_WIDTH + X_W + Y_W + 1
`else
  localparam int EVT_W     = X_W + Y_W + 1
`endif
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [ROWS-1:0][COLS-1:0] gnt_i,
  input  logic                      polarity_i,
  output logic                      arb_enable_o,
  output logic [ROWS-1:0][COLS-1:0] pix_clr_o,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [EVT_W-1:0]          evt_data_o,
  output logic                      overflow_stall_o,
  output logic                      err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ARB, CAPTURE_WAIT, CLEAR} state_t;

  state_t                    state, next_state;
  logic                      push, pop, full, gnt_any;
  logic [X_W-1:0]            x_idx;
  logic [Y_W-1:0]            y_idx;
  logic [ROWS-1:0][COLS-1:0] clr_mask;
  logic [EVT_W-1:0]          evt_word;
  logic [EVT_W-1:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;

  assign gnt_any = |gnt_i;

  // Lowest row wins, then lowest column inside that row; a multi-hot grant clears one pixel only.
  always_comb begin
    x_idx    = '0;
    y_idx    = '0;
    clr_mask = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (|gnt_i[r]) x_idx = X_W'(r);
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (gnt_i[x_idx][c]) y_idx = Y_W'(c);
    end
    clr_mask[x_idx][y_idx] = gnt_any;
  end

`ifdef EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)      ts <= '0;
    else if (enable_i) ts <= ts + 1'b1;
  end

  assign evt_word = {ts, x_idx, y_idx, polarity_i};
`else
  assign evt_word = {x_idx, y_idx, polarity_i};
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state       = state;
    arb_enable_o     = 1'b0;
    overflow_stall_o = 1'b0;
    push             = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) next_state = ARB;
      end
      ARB: begin
        arb_enable_o = !full;
        if (gnt_any) begin
          if (!full) begin
            push       = 1'b1;
            next_state = CLEAR;
          end else begin
            next_state = CAPTURE_WAIT;
          end
        end else if (!enable_i) begin
          next_state = IDLE;
        end
      end
      CAPTURE_WAIT: begin
        overflow_stall_o = 1'b1;
        if (!full) begin
          push       = 1'b1;
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        if (!gnt_any) next_state = enable_i ? ARB : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign pix_clr_o = push ? clr_mask : '0;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                   err_o <= 1'b0;
    else if ($countones(gnt_i) > 1) err_o <= 1'b1;
  end

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign evt_valid_o = (count != '0);
  assign pop         = evt_valid_o & evt_ready_i;
  // Storage is not reset, so the head is masked while empty.
  assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= evt_word;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
